// File: rtl/sobel_line_ctrl_if.sv
// Pixel handshake and line-buffer/kernel signals between the Sobel controller
// and its datapath. The controller side uses the master modport.
interface sobel_line_ctrl_if #(
    parameter int COL_W = 10
);
    // A pixel moves on every clock edge where pix_valid and pix_ready are both
    // high. The source holds the pixel while pix_ready is low, and pix_valid
    // during that time has no effect.
    logic             pix_valid;
    logic             pix_ready;
    logic [2:0]       w_en;
    logic [COL_W-1:0] wr_addr;
    logic [1:0]       top_line;
    logic             win_valid;
    logic [COL_W-1:0] win_col;

    modport master (
        input  pix_valid,
        output pix_ready, w_en, wr_addr, top_line, win_valid, win_col
    );

    modport slave (
        output pix_valid,
        input  pix_ready, w_en, wr_addr, top_line, win_valid, win_col
    );
endinterface

// File: rtl/sobel_line_ctrl.sv
// Frame sequencer for the Sobel datapath. It steps rows across three line
// buffers and flags each complete 3x3 window. led shows the FSM state.
module sobel_line_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          sel,
    sobel_line_ctrl_if.master   px,
    output logic [1:0]          ch_sel,
    output logic                busy,
    output logic                done,
    output logic [2:0]          led
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       line_q, line_d;
    logic [1:0]       ch_q, ch_d;
    logic             winv_q, winv_d;
    logic [COL_W-1:0] wincol_q, wincol_d;
    logic             xfer;

    assign busy         = (state_q == S_FILL) || (state_q == S_RUN);
    // Gated by rst so that no pixel is taken in the cycle reset is applied.
    assign px.pix_ready = busy && !rst;
    assign xfer         = px.pix_valid && px.pix_ready;
    assign px.w_en      = xfer ? (3'b001 << line_q) : 3'b000;
    assign px.wr_addr   = col_q;
    assign px.top_line  = (line_q == 2'd2) ? 2'd0 : line_q + 2'd1;
    assign px.win_valid = winv_q;
    assign px.win_col   = wincol_q;
    assign ch_sel       = ch_q;
    assign done         = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        line_d   = line_q;
        ch_d     = ch_q;
        winv_d   = 1'b0;
        wincol_d = wincol_q;
        led      = 3'b001;
        case (state_q)
            S_IDLE: begin
                led = 3'b001;
                if (start && (sel != 3'b000)) begin
                    ch_d    = sel[0] ? 2'd0 : (sel[1] ? 2'd1 : 2'd2);
                    row_d   = '0;
                    col_d   = '0;
                    line_d  = 2'd0;
                    state_d = S_FILL;
                end
            end
            S_FILL, S_RUN: begin
                led = (state_q == S_FILL) ? 3'b010 : 3'b100;
                if (xfer) begin
                    if ((state_q == S_RUN) && (col_q >= COL_W'(2))) begin
                        winv_d   = 1'b1;
                        wincol_d = col_q;
                    end
                    if (col_q == COL_LAST) begin
                        col_d  = '0;
                        line_d = (line_q == 2'd2) ? 2'd0 : line_q + 2'd1;
                        // The last row wraps to 0 rather than overflowing the counter.
                        if ((state_q == S_RUN) && (row_q == ROW_LAST)) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            if ((state_q == S_FILL) && (row_q == ROW_W'(1))) begin
                                state_d = S_RUN;
                            end
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_DONE: begin
                led     = 3'b111;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            line_q   <= 2'd0;
            ch_q     <= 2'd0;
            winv_q   <= 1'b0;
            wincol_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            line_q   <= line_d;
            ch_q     <= ch_d;
            winv_q   <= winv_d;
            wincol_q <= wincol_d;
        end
    end
endmodule
